// File: rtl/adder_result_collector.sv
// adder_result_collector: captures {carry,sum} results from the 8-bit adder
// into a first-word-fall-through FIFO, drained by a valid/ready consumer, and
// keeps a modulo running total of every accepted result.
module adder_result_collector #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Data_ready,
    input  logic [7:0]       Sum_result,
    input  logic             Sum_carry,
    input  logic             Clr_acc,
    input  logic             Out_ready,
    output logic             Out_valid,
    output logic [8:0]       Out_data,
    output logic [CW-1:0]    Fifo_count,
    output logic [ACC_W-1:0] Acc_total,
    output logic             Acc_wrap,
    output logic             Overflow
);

    // Zero-extended add; the extra top bit is the wrap indication.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] base,
                                               input logic [8:0] val);
        acc_add = {1'b0, base} + (ACC_W+1)'(val);
    endfunction

    logic [8:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [8:0]       din;
    logic             full;
    logic             push;
    logic             pop;
    logic [ACC_W:0]   acc_sum;

    assign din       = {Sum_carry, Sum_result};
    assign full      = (count == CW'(DEPTH));
    assign Out_valid = (count != '0);
    assign pop       = Out_valid && Out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push      = Data_ready && (!full || pop);
    assign Out_data  = Out_valid ? mem[rd_ptr] : 9'd0;
    assign Fifo_count = count;
    assign acc_sum   = acc_add(Acc_total, din);

    // Storage write; payload is data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (Data_ready && !push) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Running total; a clear in the same cycle as a push restarts from that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            Acc_total <= '0;
            Acc_wrap  <= 1'b0;
        end else if (Clr_acc) begin
            Acc_total <= push ? ACC_W'(din) : '0;
            Acc_wrap  <= 1'b0;
        end else if (push) begin
            Acc_total <= acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) begin
                Acc_wrap <= 1'b1;
            end
        end
    end

endmodule
